// File: rtl/dp_sequencer_if.sv
// Command handshake bundle between the control unit and dp_sequencer.
interface dp_sequencer_if;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [4:0] CMD_OP;
  logic [3:0] CMD_RN;
  logic [3:0] CMD_RM;
  logic [3:0] CMD_RD;
  logic       CMD_S;

  modport master (
    output CMD_VALID, CMD_OP, CMD_RN, CMD_RM, CMD_RD, CMD_S,
    input  CMD_READY
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_RN, CMD_RM, CMD_RD, CMD_S,
    output CMD_READY
  );
endinterface

// File: rtl/dp_sequencer.sv
// Buffers ALU commands and steps each through a READ/WRITE sequence driving
// the register-file selects, write strobe, ALU controls and the NZCV register.
module dp_sequencer #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic               Clk,
  input  logic               RESET,
  dp_sequencer_if.slave      cmd,
  input  logic [3:0]         FLAGS_OUT,
  output logic [19:0]        RSLCT,
  output logic               LOAD,
  output logic               IR_CU,
  output logic [4:0]         OP,
  output logic               S,
  output logic               ALU_OUT,
  output logic [3:0]         FLAGS,
  output logic               BUSY,
  output logic               DONE,
  output logic [CNT_W-1:0]   RETIRED
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_t;

  typedef struct packed {
    logic [4:0] op;
    logic [3:0] rn;
    logic [3:0] rm;
    logic [3:0] rd;
    logic       s;
  } cmd_t;

  cmd_t            mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ready_q, ready_d;
  state_t          state_q, state_d;
  cmd_t            cmd_q, cmd_d, cmd_in;
  logic            push, pop, wb;

  logic [19:0]     rslct_q, rslct_d;
  logic            load_q, load_d;
  logic [4:0]      op_q, op_d;
  logic            s_q, s_d;
  logic            aluo_q, aluo_d;
  logic [3:0]      flags_q, flags_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  assign cmd_in = '{op: cmd.CMD_OP, rn: cmd.CMD_RN, rm: cmd.CMD_RM,
                    rd: cmd.CMD_RD, s: cmd.CMD_S};
  // ready_q is zero whenever occupancy is full, so a full FIFO is never pushed
  assign push   = cmd.CMD_VALID && ready_q;

  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    pop       = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (count_q != '0) begin pop = 1'b1; state_d = ST_READ; end
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: begin
        if (count_q != '0) begin pop = 1'b1; state_d = ST_READ; end
        else               state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
    if (pop) cmd_d = mem_q[rd_ptr_q];

    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    // Outputs are decoded from the next state so they register in step with it
    wb      = !(cmd_d.op[4] == 1'b0 && cmd_d.op[3:2] == 2'b10);
    rslct_d = '0;
    op_d    = '0;
    s_d     = 1'b0;
    aluo_d  = 1'b0;
    load_d  = 1'b0;
    if (state_d != ST_IDLE) begin
      rslct_d = {4'h0, cmd_d.rd, 4'h0, cmd_d.rm, cmd_d.rn};
      op_d    = cmd_d.op;
      aluo_d  = 1'b1;
    end
    if (state_d == ST_WRITE) begin
      s_d    = cmd_d.s;
      load_d = wb;
    end

    flags_d   = flags_q;
    retired_d = retired_q;
    done_d    = 1'b0;
    if (state_q == ST_WRITE) begin
      done_d    = 1'b1;
      retired_d = retired_q + CNT_W'(1);
      if (cmd_q.s) flags_d = FLAGS_OUT;
    end

    ready_d = (count_d != FULL_CNT);
    busy_d  = (count_d != '0) || (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ready_q   <= 1'b0;
      rslct_q   <= '0;
      load_q    <= 1'b0;
      op_q      <= '0;
      s_q       <= 1'b0;
      aluo_q    <= 1'b0;
      flags_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      rslct_q   <= rslct_d;
      load_q    <= load_d;
      op_q      <= op_d;
      s_q       <= s_d;
      aluo_q    <= aluo_d;
      flags_q   <= flags_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      retired_q <= retired_d;
    end
  end

  assign cmd.CMD_READY = ready_q;
  assign RSLCT         = rslct_q;
  assign LOAD          = load_q;
  assign IR_CU         = 1'b1;
  assign OP            = op_q;
  assign S             = s_q;
  assign ALU_OUT       = aluo_q;
  assign FLAGS         = flags_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign RETIRED       = retired_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed self-checking bench for dp_sequencer (FIFO_DEPTH=2, CNT_W=4).
module tb_dp_sequencer;

  logic        Clk = 1'b0;
  logic        RESET;
  logic [3:0]  FLAGS_OUT;
  logic [19:0] RSLCT;
  logic        LOAD, IR_CU, S, ALU_OUT, BUSY, DONE;
  logic [4:0]  OP;
  logic [3:0]  FLAGS;
  logic [3:0]  RETIRED;

  dp_sequencer_if cif ();

  dp_sequencer #(.FIFO_DEPTH(2), .CNT_W(4)) dut (
    .Clk       (Clk),
    .RESET     (RESET),
    .cmd       (cif),
    .FLAGS_OUT (FLAGS_OUT),
    .RSLCT     (RSLCT),
    .LOAD      (LOAD),
    .IR_CU     (IR_CU),
    .OP        (OP),
    .S         (S),
    .ALU_OUT   (ALU_OUT),
    .FLAGS     (FLAGS),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RETIRED   (RETIRED)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int load_cnt = 0;
  int done_cnt = 0;
  int dbl_load = 0;
  logic prev_load = 1'b0;
  logic stalled;
  int rd_log[$];
  int done_cyc[$];

  always @(posedge Clk) cyc++;

  always @(negedge Clk) begin
    if (LOAD) begin
      load_cnt++;
      rd_log.push_back(int'(RSLCT[15:12]));
    end
    if (LOAD && prev_load) dbl_load++;
    prev_load = LOAD;
    if (DONE) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Presents a command at a negedge, holds until accepted, returns at the next negedge
  task automatic send(input logic [4:0] op, input logic [3:0] rn, input logic [3:0] rm,
                      input logic [3:0] rd, input logic s);
    logic accepted;
    accepted = 1'b0;
    cif.CMD_VALID = 1'b1;
    cif.CMD_OP = op; cif.CMD_RN = rn; cif.CMD_RM = rm; cif.CMD_RD = rd; cif.CMD_S = s;
    for (int k = 0; k < 50; k++) begin
      if (cif.CMD_READY) begin accepted = 1'b1; break; end
      stalled = 1'b1;
      @(negedge Clk);
    end
    check("accept", {31'd0, accepted}, 32'd1);
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge Clk);
      if (!BUSY) begin idle = 1'b1; break; end
    end
    check("idle_timeout", {31'd0, idle}, 32'd1);
    @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, d0, n;
    RESET = 1'b1;
    FLAGS_OUT = 4'h0;
    cif.CMD_VALID = 1'b0;
    cif.CMD_OP = '0; cif.CMD_RN = '0; cif.CMD_RM = '0; cif.CMD_RD = '0; cif.CMD_S = 1'b0;
    stalled = 1'b0;

    // Reset values
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_ready_low", {31'd0, cif.CMD_READY}, 32'd0);
    RESET = 1'b0;
    @(negedge Clk);
    check("rst_ready_high", {31'd0, cif.CMD_READY}, 32'd1);
    check("rst_rslct", {12'd0, RSLCT}, 32'd0);
    check("rst_load", {31'd0, LOAD}, 32'd0);
    check("rst_op", {27'd0, OP}, 32'd0);
    check("rst_s_aluout", {30'd0, S, ALU_OUT}, 32'd0);
    check("rst_flags", {28'd0, FLAGS}, 32'd0);
    check("rst_busy_done", {30'd0, BUSY, DONE}, 32'd0);
    check("rst_retired", {28'd0, RETIRED}, 32'd0);
    check("ir_cu", {31'd0, IR_CU}, 32'd1);

    // Single command, cycle-by-cycle
    FLAGS_OUT = 4'hA;
    send(5'd4, 4'd1, 4'd2, 4'd3, 1'b1);
    cif.CMD_VALID = 1'b0;
    check("single_t0_busy", {31'd0, BUSY}, 32'd1);
    check("single_t0_aluout", {31'd0, ALU_OUT}, 32'd0);
    @(negedge Clk);
    check("single_rd_rslct", {12'd0, RSLCT}, 32'h03021);
    check("single_rd_op", {27'd0, OP}, 32'd4);
    check("single_rd_s_aluo_load", {29'd0, S, ALU_OUT, LOAD}, 32'b010);
    @(negedge Clk);
    check("single_wr_rslct", {12'd0, RSLCT}, 32'h03021);
    check("single_wr_s_aluo_load", {29'd0, S, ALU_OUT, LOAD}, 32'b111);
    check("single_wr_flags_old", {28'd0, FLAGS}, 32'h0);
    @(negedge Clk);
    check("single_done", {31'd0, DONE}, 32'd1);
    check("single_flags", {28'd0, FLAGS}, 32'hA);
    check("single_retired", {28'd0, RETIRED}, 32'd1);
    check("single_load_off", {31'd0, LOAD}, 32'd0);
    @(negedge Clk);
    check("single_done_pulse", {30'd0, DONE, BUSY}, 32'd0);
    check("single_load_cnt", load_cnt, 32'd1);

    // Compare op: flags update, no write strobe
    FLAGS_OUT = 4'h5;
    l0 = load_cnt; d0 = done_cnt;
    send(5'd10, 4'd4, 4'd5, 4'd6, 1'b1);
    cif.CMD_VALID = 1'b0;
    wait_idle();
    check("cmp_no_load", load_cnt - l0, 32'd0);
    check("cmp_flags", {28'd0, FLAGS}, 32'h5);
    check("cmp_done", done_cnt - d0, 32'd1);

    // S=0: flags held, one write strobe
    FLAGS_OUT = 4'hF;
    l0 = load_cnt;
    send(5'd4, 4'd7, 4'd8, 4'd9, 1'b0);
    cif.CMD_VALID = 1'b0;
    wait_idle();
    check("s0_flags", {28'd0, FLAGS}, 32'h5);
    check("s0_load", load_cnt - l0, 32'd1);
    check("s0_retired", {28'd0, RETIRED}, 32'd3);

    // Back-pressure: four commands held back to back
    stalled = 1'b0;
    for (int i = 0; i < 4; i++) send(5'd4, 4'd1, 4'd2, 4'(4 + i), 1'b0);
    cif.CMD_VALID = 1'b0;
    wait_idle();
    check("bp_stall_seen", {31'd0, stalled}, 32'd1);
    n = rd_log.size();
    for (int i = 0; i < 4; i++) check("bp_order", rd_log[n - 4 + i], 32'(4 + i));
    n = done_cyc.size();
    for (int i = 1; i < 4; i++)
      check("bp_spacing", done_cyc[n - 4 + i] - done_cyc[n - 5 + i], 32'd2);
    check("bp_retired", {28'd0, RETIRED}, 32'd7);
    check("no_double_load", dbl_load, 32'd0);

    // Reset mid-stream, 3 cycles, while the first command is in READ
    FLAGS_OUT = 4'h3;
    send(5'd4, 4'd1, 4'd1, 4'd1, 1'b1);
    send(5'd4, 4'd2, 4'd2, 4'd2, 1'b1);
    cif.CMD_VALID = 1'b0;
    RESET = 1'b1;
    l0 = load_cnt; d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("mrst_load", {31'd0, LOAD}, 32'd0);
      check("mrst_ready", {31'd0, cif.CMD_READY}, 32'd0);
      check("mrst_busy", {31'd0, BUSY}, 32'd0);
    end
    RESET = 1'b0;
    @(negedge Clk);
    check("mrst_ready_after", {31'd0, cif.CMD_READY}, 32'd1);
    check("mrst_retired", {28'd0, RETIRED}, 32'd0);
    check("mrst_flags", {28'd0, FLAGS}, 32'd0);
    check("mrst_rslct", {12'd0, RSLCT}, 32'd0);
    repeat (6) @(negedge Clk);
    check("mrst_fifo_discarded", load_cnt - l0, 32'd0);
    check("mrst_no_done", done_cnt - d0, 32'd0);
    check("mrst_busy_after", {31'd0, BUSY}, 32'd0);

    // Counter wrap with CNT_W=4: 17 retirements read back as 1
    d0 = done_cnt;
    for (int i = 0; i < 17; i++) send(5'd4, 4'd0, 4'd1, 4'(i), 1'b0);
    cif.CMD_VALID = 1'b0;
    wait_idle();
    check("wrap_done_cnt", done_cnt - d0, 32'd17);
    check("wrap_retired", {28'd0, RETIRED}, 32'd1);
    check("wrap_no_double_load", dbl_load, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_sequencer.md
# dp_sequencer

Command sequencer for the register-file + ARM ALU datapath. Accepts data-processing commands (ALU opcode, Rn, Rm, Rd, S) through a valid/ready handshake and buffers them in a small FIFO. It then drives the register-file select bus, write strobe and ALU controls for each command in a fixed two-state read/write sequence. It owns the architectural NZCV flag register that feeds the ALU FLAGS input and sits between the control unit and the RegisterFile/ARM_ALU pair.

## Interface
- FIFO_DEPTH, 2: command buffer depth; power of two, 2..8.
- CNT_W, 16: width of the retired-command counter.

- Clk  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command present on CMD_* this cycle.
- CMD_READY  out  1  sequencer can accept a command this cycle.
- CMD_OP  in  5  ALU opcode passed to ARM_ALU OP.
- CMD_RN  in  4  first operand register (ALU A).
- CMD_RM  in  4  second operand register (ALU B).
- CMD_RD  in  4  destination register.
- CMD_S  in  1  update flags from this command.
- FLAGS_OUT  in  4  NZCV result from ARM_ALU.
- RSLCT  out  20  register-file select: [3:0]=Rn, [7:4]=Rm, [11:8]=Rs (driven 0), [15:12]=Rd, [19:16]=0.
- LOAD  out  1  register-file write strobe, one cycle per writing command.
- IR_CU  out  1  register-file input-source select, constant 1.
- OP  out  5  ALU opcode.
- S  out  1  ALU S input.
- ALU_OUT  out  1  ALU output enable.
- FLAGS  out  4  current NZCV register, to ARM_ALU FLAGS.
- BUSY  out  1  FIFO non-empty or state not IDLE.
- DONE  out  1  one-cycle pulse per retired command.
- RETIRED  out  CNT_W  count of retired commands.

## Operation
- FIFO: push on CMD_VALID && CMD_READY. CMD_READY = !full, computed from registered occupancy only.
  - A push into a full FIFO never occurs, even when a pop happens the same cycle.
  - Pop and push in the same cycle are allowed when not full; occupancy is unchanged.
- FSM states: IDLE, READ, WRITE.
  - IDLE -> READ when FIFO non-empty. Pop the head into the command register.
  - READ -> WRITE unconditionally.
  - WRITE -> READ if FIFO non-empty (pop the next command), else IDLE.
- READ drives RSLCT from the command register, OP=cmd op, S=0, ALU_OUT=1, LOAD=0. This is the operand/ALU settle cycle.
- WRITE keeps RSLCT/OP, sets S=cmd S and ALU_OUT=1, and drives LOAD=wb.
  - wb = 0 for compare ops (OP[4]==0 && OP[3:2]==2'b10, i.e. 8..11), else 1.
  - At the end of WRITE: if cmd S, FLAGS <= FLAGS_OUT. DONE pulses next cycle. RETIRED increments.
- RETIRED wraps from all-ones to 0.
- Rd==15 is written like any other register; PC handling is outside this block.
- All control outputs are registered.

## Timing
- Reset values: CMD_READY=0 during RESET and 1 the cycle after; RSLCT=0; LOAD=0; OP=0; S=0; ALU_OUT=0; FLAGS=0; BUSY=0; DONE=0; RETIRED=0; state IDLE; FIFO empty. IR_CU=1 always.
- RESET mid-command discards the FIFO and the in-flight command. No LOAD is issued after the RESET edge, and FLAGS are not updated.
- Latency, idle sequencer: command accepted at edge t; READ during cycle t+1..t+2; WRITE (LOAD=1) during t+2..t+3; register-file write and flag update at edge t+3; DONE high t+3..t+4.
- Throughput: back-to-back commands retire every 2 cycles with no IDLE cycle between them.
- LOAD is never high for two consecutive cycles. LOAD is high only in WRITE.
- FLAGS change only at the end of WRITE with S=1. A following command's READ sees the updated FLAGS.

## Test plan
- Reset: assert RESET 3 cycles mid-stream -> all outputs at reset values next cycle, FIFO empty, no LOAD pulse, RETIRED=0.
- Single command OP=4, Rn=1, Rm=2, Rd=3, S=1 accepted at edge t -> RSLCT=20'h03021 from t+1, LOAD=1 only in cycle t+2..t+3, FLAGS=FLAGS_OUT after t+3, DONE one pulse, RETIRED=1.
- Compare: OP=10, S=1 -> LOAD stays 0 throughout, FLAGS updated, DONE pulses.
- S=0 command with FLAGS_OUT=4'hF -> FLAGS unchanged, LOAD pulses once.
- Back-pressure: hold CMD_VALID with 4 commands while the sequencer is busy -> CMD_READY drops with 2 buffered, none lost. Commands retire in order at 2-cycle spacing, RETIRED=4.
- Counter wrap (CNT_W=4): retire 17 commands -> RETIRED reads 1.
